sao_eo_stat_ctrl: RTL and testbench



---
 rtl/sao_eo_stat_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_sao_eo_stat_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sao_eo_stat_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sao_eo_stat_ctrl
// Brief    : SAO edge-offset class-0 (horizontal) statistics sequencer.
//            Takes rec/org sample pairs in raster order over valid/ready.
//            Forms a left/middle/right window for each interior column and
//            classifies the middle sample into edge category 1..4. Then it
//            accumulates a per-category count and a sum of (org - rec).
//            Pipeline: window at the accept edge, category/diff one edge
//            later, accumulators one edge after that.
// Options  : SAO_STAT_CAT0_EN - adds stat_cnt0, the count of evaluated
//            samples that fall into category 0.
// Revision : 1.0 - initial release
// ============================================================================
module sao_eo_stat_ctrl #(
  parameter int BIT_DEPTH = 8,
  parameter int MAX_DIM   = 64,
  parameter int CNT_W     = $clog2(MAX_DIM * MAX_DIM) + 1,
  parameter int SUM_W     = CNT_W + BIT_DEPTH + 1,
  parameter int DIM_W     = $clog2(MAX_DIM)
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   start,
  input  logic [DIM_W-1:0]       width_m1,
  input  logic [DIM_W-1:0]       height_m1,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [BIT_DEPTH-1:0]   pix_rec,
  input  logic [BIT_DEPTH-1:0]   pix_org,
  output logic                   busy,
  output logic                   done,
  // Category k (1..4) lives in field k-1; each stat_sum field is two's complement
  output logic [4*CNT_W-1:0]     stat_cnt,
  output logic [4*SUM_W-1:0]     stat_sum
`ifdef SAO_STAT_CAT0_EN
  ,
  output logic [CNT_W-1:0]       stat_cnt0
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN0 = 2'd2,
    ST_DRAIN1 = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [DIM_W-1:0]       width_q, width_d;
  logic [DIM_W-1:0]       height_q, height_d;
  logic [DIM_W-1:0]       col_q, col_d;
  logic [DIM_W-1:0]       row_q, row_d;
  logic                   done_q, done_d;
  logic                   w_clear;
  logic                   w_accept;

  // Window: rec of columns c-2, c-1, c and org of columns c-1, c
  logic [BIT_DEPTH-1:0]   rec_l_q, rec_l_d;
  logic [BIT_DEPTH-1:0]   rec_m_q, rec_m_d;
  logic [BIT_DEPTH-1:0]   rec_r_q, rec_r_d;
  logic [BIT_DEPTH-1:0]   org_m_q, org_m_d;
  logic [BIT_DEPTH-1:0]   org_r_q, org_r_d;
  logic                   win_vld_q, win_vld_d;

  // Classification stage
  logic [2:0]             cat_q, cat_d;
  logic [BIT_DEPTH:0]     diff_q, diff_d;
  logic                   eval_q, eval_d;

  // Accumulators
  logic [4*CNT_W-1:0]     cnt_q, cnt_d;
  logic [4*SUM_W-1:0]     sum_q, sum_d;
  logic [SUM_W-1:0]       w_diff_ext;
`ifdef SAO_STAT_CAT0_EN
  logic [CNT_W-1:0]       cnt0_q, cnt0_d;
`endif

  assign w_accept   = pix_valid && (state_q == ST_RUN);
  assign pix_ready  = (state_q == ST_RUN);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign stat_cnt   = cnt_q;
  assign stat_sum   = sum_q;
`ifdef SAO_STAT_CAT0_EN
  assign stat_cnt0  = cnt0_q;
`endif

  // Sign of (a - b) as a 2-bit two's complement value: +1, 0 or -1
  function automatic logic [1:0] sgn(input logic [BIT_DEPTH-1:0] a,
                                     input logic [BIT_DEPTH-1:0] b);
    if (a > b)      return 2'b01;
    else if (a < b) return 2'b11;
    else            return 2'b00;
  endfunction

  // Next state, dimension latch and raster position counters
  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    col_d    = col_q;
    row_d    = row_q;
    done_d   = 1'b0;
    w_clear  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          width_d  = width_m1;
          height_d = height_m1;
          col_d    = '0;
          row_d    = '0;
          w_clear  = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          if (col_q == width_q) begin
            col_d = '0;
            if (row_q == height_q) state_d = ST_DRAIN0;
            else                   row_d   = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_DRAIN0: state_d = ST_DRAIN1;
      ST_DRAIN1: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Window shift on every accepted sample; a full in-row window exists from column 2 on
  always_comb begin
    rec_l_d   = rec_l_q;
    rec_m_d   = rec_m_q;
    rec_r_d   = rec_r_q;
    org_m_d   = org_m_q;
    org_r_d   = org_r_q;
    win_vld_d = 1'b0;
    if (w_accept) begin
      rec_l_d   = rec_m_q;
      rec_m_d   = rec_r_q;
      rec_r_d   = pix_rec;
      org_m_d   = org_r_q;
      org_r_d   = pix_org;
      win_vld_d = (col_q >= DIM_W'(2));
    end
  end

  // Edge category and (org - rec) of the middle sample
  always_comb begin
    logic [2:0] s;
    logic [1:0] sl;
    logic [1:0] sr;
    sl     = sgn(rec_m_q, rec_l_q);
    sr     = sgn(rec_m_q, rec_r_q);
    s      = {sl[1], sl} + {sr[1], sr};
    eval_d = win_vld_q;
    diff_d = {1'b0, org_m_q} - {1'b0, rec_m_q};
    case (s)
      3'b110:  cat_d = 3'd1;  // -2: local minimum
      3'b111:  cat_d = 3'd2;  // -1: concave corner
      3'b001:  cat_d = 3'd3;  // +1: convex corner
      3'b010:  cat_d = 3'd4;  // +2: local maximum
      default: cat_d = 3'd0;
    endcase
  end

  assign w_diff_ext = {{(SUM_W-BIT_DEPTH-1){diff_q[BIT_DEPTH]}}, diff_q};

  // Accumulator update; an accepted start clears everything for the new block
  always_comb begin
    cnt_d = cnt_q;
    sum_d = sum_q;
`ifdef SAO_STAT_CAT0_EN
    cnt0_d = cnt0_q;
`endif
    if (w_clear) begin
      cnt_d = '0;
      sum_d = '0;
`ifdef SAO_STAT_CAT0_EN
      cnt0_d = '0;
`endif
    end else if (eval_q) begin
      for (int k = 0; k < 4; k++) begin
        if (cat_q == 3'(k + 1)) begin
          cnt_d[k*CNT_W +: CNT_W] = cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
          sum_d[k*SUM_W +: SUM_W] = sum_q[k*SUM_W +: SUM_W] + w_diff_ext;
        end
      end
`ifdef SAO_STAT_CAT0_EN
      if (cat_q == 3'd0) cnt0_d = cnt0_q + CNT_W'(1);
`endif
    end
  end

  // State and datapath registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= ST_IDLE;
      width_q   <= '0;
      height_q  <= '0;
      col_q     <= '0;
      row_q     <= '0;
      done_q    <= 1'b0;
      rec_l_q   <= '0;
      rec_m_q   <= '0;
      rec_r_q   <= '0;
      org_m_q   <= '0;
      org_r_q   <= '0;
      win_vld_q <= 1'b0;
      cat_q     <= '0;
      diff_q    <= '0;
      eval_q    <= 1'b0;
      cnt_q     <= '0;
      sum_q     <= '0;
`ifdef SAO_STAT_CAT0_EN
      cnt0_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      height_q  <= height_d;
      col_q     <= col_d;
      row_q     <= row_d;
      done_q    <= done_d;
      rec_l_q   <= rec_l_d;
      rec_m_q   <= rec_m_d;
      rec_r_q   <= rec_r_d;
      org_m_q   <= org_m_d;
      org_r_q   <= org_r_d;
      win_vld_q <= win_vld_d;
      cat_q     <= cat_d;
      diff_q    <= diff_d;
      eval_q    <= eval_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
`ifdef SAO_STAT_CAT0_EN
      cnt0_q    <= cnt0_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sao_eo_stat_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sao_eo_stat_ctrl
// Brief    : Directed self-checking bench for sao_eo_stat_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sao_eo_stat_ctrl;

  localparam int CNT_W = 13;
  localparam int SUM_W = 22;

  logic                 clk = 1'b0;
  logic                 arst_n;
  logic                 start;
  logic [5:0]           width_m1;
  logic [5:0]           height_m1;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [7:0]           pix_rec;
  logic [7:0]           pix_org;
  logic                 busy;
  logic                 done;
  logic [4*CNT_W-1:0]   stat_cnt;
  logic [4*SUM_W-1:0]   stat_sum;
`ifdef SAO_STAT_CAT0_EN
  logic [CNT_W-1:0]     stat_cnt0;
`endif

  sao_eo_stat_ctrl dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .start     (start),
    .width_m1  (width_m1),
    .height_m1 (height_m1),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_rec   (pix_rec),
    .pix_org   (pix_org),
    .busy      (busy),
    .done      (done),
    .stat_cnt  (stat_cnt),
    .stat_sum  (stat_sum)
`ifdef SAO_STAT_CAT0_EN
    ,
    .stat_cnt0 (stat_cnt0)
`endif
  );

  always #5 clk = ~clk;

  int passed   = 0;
  int total    = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int last_acc = 0;
  logic [7:0] rec_mem [0:4095];
  logic [7:0] org_mem [0:4095];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic signed [63:0] cnt_of(input int k);
    logic signed [63:0] r;
    r = {51'b0, stat_cnt[k*CNT_W +: CNT_W]};
    return r;
  endfunction

  function automatic logic signed [63:0] sum_of(input int k);
    logic signed [63:0] r;
    r = $signed(stat_sum[k*SUM_W +: SUM_W]);
    return r;
  endfunction

  task automatic chk_stats(input string tag, input int c1, input int c2, input int c3,
                           input int c4, input int s1, input int s2, input int s3,
                           input int s4);
    int ce[4];
    int se[4];
    ce = '{c1, c2, c3, c4};
    se = '{s1, s2, s3, s4};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_cnt%0d", tag, k + 1), cnt_of(k), ce[k]);
      chk($sformatf("%s_sum%0d", tag, k + 1), sum_of(k), se[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int w, input int h);
    start     = 1'b1;
    width_m1  = 6'(w - 1);
    height_m1 = 6'(h - 1);
    step();
    start     = 1'b0;
  endtask

  // Offer samples first..first+n-1 from the memories; optional random bubbles
  task automatic feed(input int first, input int n, input bit gaps);
    for (int i = first; i < first + n; i++) begin
      int g;
      int guard;
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      if (g > 0) begin
        pix_valid = 1'b0;
        repeat (g) step();
      end
      pix_valid = 1'b1;
      pix_rec   = rec_mem[i];
      pix_org   = org_mem[i];
      guard     = 0;
      while (pix_ready !== 1'b1 && guard < 20) begin
        step();
        guard++;
      end
      if (guard >= 20) chk($sformatf("ready_timeout_%0d", i), pix_ready, 1);
      step();
      last_acc = cyc;
    end
    pix_valid = 1'b0;
  endtask

  // Called right after the last accept edge T: checks T+1 and T+2 status
  task automatic finish_block(input string tag);
    step();
    chk({tag, "_busy_t1"}, busy, 1);
    chk({tag, "_done_t1"}, done, 0);
    step();
    chk({tag, "_done_t2"}, done, 1);
    chk({tag, "_busy_t2"}, busy, 0);
    chk({tag, "_ready_t2"}, pix_ready, 0);
  endtask

  initial begin
    int d0;
    arst_n    = 1'b0;
    start     = 1'b0;
    width_m1  = '0;
    height_m1 = '0;
    pix_valid = 1'b0;
    pix_rec   = '0;
    pix_org   = '0;
    repeat (2) step();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", pix_ready, 0);
    chk_stats("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    arst_n = 1'b1;
    step();

    // Single valley: middle 5 below both 10s -> cat1, diff 8-5 = +3
    rec_mem[0] = 8'd10; rec_mem[1] = 8'd5; rec_mem[2] = 8'd10;
    org_mem[0] = 8'd0;  org_mem[1] = 8'd8; org_mem[2] = 8'd0;
    do_start(3, 1);
    chk("valley_busy", busy, 1);
    feed(0, 3, 1'b0);
    finish_block("valley");
    chk_stats("valley", 1, 0, 0, 0, 3, 0, 0, 0);

    // Back-to-back start in the done cycle; mixed categories
    // rec [5,5,4,5,9]: col1 s=0+1 -> cat3; col2 s=-1-1 -> cat1; col3 s=+1-1 -> cat0
    rec_mem[0] = 8'd5; rec_mem[1] = 8'd5; rec_mem[2] = 8'd4;
    rec_mem[3] = 8'd5; rec_mem[4] = 8'd9;
    for (int i = 0; i < 5; i++) org_mem[i] = rec_mem[i] + 8'd1;
    do_start(5, 1);
    chk("b2b_busy", busy, 1);
    chk("b2b_done_low", done, 0);
    chk("b2b_cleared", cnt_of(0), 0);
    feed(0, 5, 1'b0);
    finish_block("mixed");
    chk_stats("mixed", 1, 0, 1, 0, 1, 0, 1, 0);
    repeat (3) step();
    chk("hold_cnt3", cnt_of(2), 1);
    chk("hold_sum1", sum_of(0), 1);

    // Row boundary with a start issued mid-block (must be ignored)
    // row0 [9,0,9] -> cat1, diff 4-0; row1 [0,9,0] -> cat4, diff 4-9
    rec_mem[0] = 8'd9; rec_mem[1] = 8'd0; rec_mem[2] = 8'd9;
    rec_mem[3] = 8'd0; rec_mem[4] = 8'd9; rec_mem[5] = 8'd0;
    for (int i = 0; i < 6; i++) org_mem[i] = 8'd4;
    do_start(3, 2);
    feed(0, 5, 1'b0);
    start = 1'b1; width_m1 = 6'd0; height_m1 = 6'd0;
    step();
    start = 1'b0;
    chk("ign_start_busy", busy, 1);
    chk("ign_start_keep", cnt_of(0), 1);
    feed(5, 1, 1'b0);
    finish_block("rowb");
    chk_stats("rowb", 1, 0, 0, 1, 4, 0, 0, -5);

    // Degenerate width 2 with bubbles: nothing evaluated, one done pulse
    step();
    chk("degen_ready_idle", pix_ready, 0);
    for (int i = 0; i < 6; i++) begin
      rec_mem[i] = 8'($urandom_range(0, 255));
      org_mem[i] = 8'($urandom_range(0, 255));
    end
    d0 = done_cnt;
    do_start(2, 3);
    feed(0, 6, 1'b1);
    finish_block("degen");
    chk_stats("degen", 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("degen_done_once", done_cnt - d0, 1);
    chk("degen_done_low", done, 0);

    // Reset mid-block while a count is already non-zero
    for (int i = 0; i < 4; i++) org_mem[i] = 8'd4;
    rec_mem[0] = 8'd9; rec_mem[1] = 8'd0; rec_mem[2] = 8'd9; rec_mem[3] = 8'd0;
    do_start(3, 2);
    feed(0, 4, 1'b0);
    step();
    chk("prerst_cnt1", cnt_of(0), 1);
    arst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", pix_ready, 0);
    chk("midrst_done", done, 0);
    chk_stats("midrst", 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    arst_n = 1'b1;
    step();
    chk("postrst_busy", busy, 0);

    // 64x64 alternating 0/255 columns, org 0
    // odd columns 1..61 -> cat4, diff -255; even 2..62 -> cat1, diff 0; 31 each per row
    for (int i = 0; i < 4096; i++) begin
      rec_mem[i] = ((i % 64) % 2 == 1) ? 8'd255 : 8'd0;
      org_mem[i] = 8'd0;
    end
    do_start(64, 64);
    feed(0, 4096, 1'b0);
    finish_block("alt");
    chk_stats("alt", 1984, 0, 0, 1984, 0, 0, 0, -505920);
`ifdef SAO_STAT_CAT0_EN
    chk("alt_cnt0", {51'b0, stat_cnt0}, 0);
`endif

    // 64x64 flat block of 255, org 0: every evaluated sample is category 0
    for (int i = 0; i < 4096; i++) begin
      rec_mem[i] = 8'd255;
      org_mem[i] = 8'd0;
    end
    do_start(64, 64);
    feed(0, 4096, 1'b0);
    finish_block("flat");
    chk_stats("flat", 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef SAO_STAT_CAT0_EN
    chk("flat_cnt0", {51'b0, stat_cnt0}, 3968);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
